// File: rtl/conv_kernel_loader_pkg.sv
// conv_kernel_loader_pkg
//   Shared definitions for the convolution kernel-weight loader: default
//   parameter values, the derived widths of the default configuration, the
//   loader FSM state type and a width helper used by the port declarations.
package conv_kernel_loader_pkg;

  localparam int KERNEL_SIZE_DEF            = 3;
  localparam int IN_CHANNELS_DEF            = 2;
  localparam int OUT_CHANNELS_DEF           = 2;
  localparam int BITS_PER_KERNEL_WEIGHT_DEF = 6;

  // Counter/address width that never collapses to zero bits.
  function automatic int width_min1(input int n);
    return ($clog2(n) < 1) ? 1 : $clog2(n);
  endfunction

  localparam int N_LANES = IN_CHANNELS_DEF * OUT_CHANNELS_DEF;
  localparam int WORD_W  = N_LANES * BITS_PER_KERNEL_WEIGHT_DEF;
  localparam int ADDR_W  = width_min1(KERNEL_SIZE_DEF * KERNEL_SIZE_DEF);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    WRITE,
    DONE
  } kernel_loader_state_t;

endpackage

// File: rtl/conv_weight_packer.sv
// conv_weight_packer
//   Collects NUM_LANES weights of WEIGHT_W bits into one memory word. The
//   first weight after a clear lands in the least significant lane.
// Ports:
//   clk, rst    clock, synchronous active-high reset
//   clear_i     restart packing at lane 0
//   lane_we_i   store weight_i into the current lane and advance
//   weight_i    weight data
//   full_o      the current lane is the last one of the word
//   word_o      packed word including the weight being written this cycle
module conv_weight_packer #(
  parameter int NUM_LANES = 4,
  parameter int WEIGHT_W  = 6
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          clear_i,
  input  logic                          lane_we_i,
  input  logic [WEIGHT_W-1:0]           weight_i,
  output logic                          full_o,
  output logic [NUM_LANES*WEIGHT_W-1:0] word_o
);

  localparam int LANE_W = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;
  localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(NUM_LANES - 1);

  logic [LANE_W-1:0]             lane_q, lane_d;
  logic [NUM_LANES*WEIGHT_W-1:0] packed_q, packed_d;

  assign full_o = (lane_q == LAST_LANE);
  // Exposing the next value lets the caller capture a complete word in the
  // same cycle the final lane is accepted.
  assign word_o = packed_d;

  // NOTE: every variable gets a default at the top of the block, so no path
  // leaves it unassigned and no latch is inferred.
  always_comb begin
    lane_d   = lane_q;
    packed_d = packed_q;
    if (clear_i) begin
      lane_d = '0;
    end else if (lane_we_i) begin
      packed_d[int'(lane_q)*WEIGHT_W +: WEIGHT_W] = weight_i;
      lane_d = full_o ? '0 : lane_q + LANE_W'(1);
    end
  end

  // NOTE: the packing register is small, so it is reset along with the
  // control state; a reset mid-load then leaves no stale lanes behind.
  always_ff @(posedge clk) begin
    if (rst) begin
      lane_q   <= '0;
      packed_q <= '0;
    end else begin
      lane_q   <= lane_d;
      packed_q <= packed_d;
    end
  end

endmodule

// File: rtl/conv_kernel_loader.sv
// conv_kernel_loader
//   Accepts a serial stream of kernel weights (addr, then ic, then oc order)
//   over valid/ready, packs N_LANES weights per kernel position and writes
//   one word per position into the kernel weight RAM. Used at network load.
// Ports:
//   clk, rst      clock, synchronous active-high reset
//   start_i       begin a full kernel load (sampled in IDLE only)
//   s_weight_i    weight data, s_valid_i / s_ready_o handshake
//   mem_we_o      one-cycle write strobe, with mem_addr_o / mem_wdata_o
//   busy_o        loader is not idle
//   done_o        one-cycle pulse after the last word is written
//   checksum_o    unsigned sum of accepted weights, only when the macro
//                 CONV_KERNEL_LOADER_CHECKSUM_EN is defined
module conv_kernel_loader
  import conv_kernel_loader_pkg::*;
#(
  parameter int KERNEL_SIZE            = KERNEL_SIZE_DEF,
  parameter int IN_CHANNELS            = IN_CHANNELS_DEF,
  parameter int OUT_CHANNELS           = OUT_CHANNELS_DEF,
  parameter int BITS_PER_KERNEL_WEIGHT = BITS_PER_KERNEL_WEIGHT_DEF
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              start_i,
  input  logic [BITS_PER_KERNEL_WEIGHT-1:0] s_weight_i,
  input  logic                              s_valid_i,
  output logic                              s_ready_o,
  output logic                              mem_we_o,
  output logic [width_min1(KERNEL_SIZE*KERNEL_SIZE)-1:0] mem_addr_o,
  output logic [IN_CHANNELS*OUT_CHANNELS*BITS_PER_KERNEL_WEIGHT-1:0] mem_wdata_o,
  output logic                              busy_o,
  output logic                              done_o
`ifdef CONV_KERNEL_LOADER_CHECKSUM_EN
  ,
  output logic [BITS_PER_KERNEL_WEIGHT+$clog2(KERNEL_SIZE*KERNEL_SIZE*IN_CHANNELS*OUT_CHANNELS+1)-1:0] checksum_o
`endif
);

  localparam int NUM_LANES  = IN_CHANNELS * OUT_CHANNELS;
  localparam int WORD_WIDTH = NUM_LANES * BITS_PER_KERNEL_WEIGHT;
  localparam int NUM_ADDR   = KERNEL_SIZE * KERNEL_SIZE;
  localparam int ADDR_WIDTH = width_min1(NUM_ADDR);
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(NUM_ADDR - 1);

  kernel_loader_state_t  state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                  mem_we_q, mem_we_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [WORD_WIDTH-1:0] mem_wdata_q, mem_wdata_d;

  logic                  lane_we;
  logic                  pack_clear;
  logic                  pack_full;
  logic [WORD_WIDTH-1:0] pack_word;
  logic                  word_done;

  conv_weight_packer #(
    .NUM_LANES (NUM_LANES),
    .WEIGHT_W  (BITS_PER_KERNEL_WEIGHT)
  ) u_packer (
    .clk       (clk),
    .rst       (rst),
    .clear_i   (pack_clear),
    .lane_we_i (lane_we),
    .weight_i  (s_weight_i),
    .full_o    (pack_full),
    .word_o    (pack_word)
  );

  always_comb begin
    state_d    = state_q;
    s_ready_o  = 1'b0;
    lane_we    = 1'b0;
    pack_clear = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start_i) begin
          state_d    = LOAD;
          pack_clear = 1'b1;
        end
      end
      LOAD: begin
        s_ready_o = 1'b1;
        if (s_valid_i) begin
          lane_we = 1'b1;
          if (pack_full) state_d = WRITE;
        end
      end
      WRITE: state_d = (addr_q == LAST_ADDR) ? DONE : LOAD;
      DONE:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // The final lane of a word is accepted in this cycle; the write strobe and
  // its address/data are registered so they appear together in WRITE.
  assign word_done = lane_we && pack_full;

  always_comb begin
    addr_d      = addr_q;
    mem_we_d    = word_done;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    if (pack_clear) begin
      addr_d = '0;
    end else if (state_q == WRITE && addr_q != LAST_ADDR) begin
      addr_d = addr_q + ADDR_WIDTH'(1);
    end
    // Address and data hold between writes, so they only load on a word.
    if (word_done) begin
      mem_addr_d  = addr_q;
      mem_wdata_d = pack_word;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge value of every other flop, independent of block order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  assign mem_we_o    = mem_we_q;
  assign mem_addr_o  = mem_addr_q;
  assign mem_wdata_o = mem_wdata_q;
  assign busy_o      = (state_q != IDLE);
  assign done_o      = (state_q == DONE);

`ifdef CONV_KERNEL_LOADER_CHECKSUM_EN
  localparam int CKS_W = BITS_PER_KERNEL_WEIGHT + $clog2(NUM_ADDR*NUM_LANES+1);

  logic [CKS_W-1:0] cks_q, cks_d;

  // Cleared when a load starts; it then only moves on accepted weights, so
  // it is stable from done_o until the next start.
  always_comb begin
    cks_d = cks_q;
    if (pack_clear) begin
      cks_d = '0;
    end else if (lane_we) begin
      cks_d = cks_q + CKS_W'(s_weight_i);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cks_q <= '0;
    end else begin
      cks_q <= cks_d;
    end
  end

  assign checksum_o = cks_q;
`endif

endmodule
